// File: rtl/aes_inv_key_scheduling.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_scheduling (with aes_sbox)
// Description : AES-128 inverse key schedule; streams round keys 10..0 over
//               a valid/ready handshake, one backward expansion step per key.
// Revision    : 1.0 - initial release
// ============================================================================

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

module aes_inv_key_scheduling #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last_in,
    input  logic [7:0]   rcon_last_in,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t       r_state;
    logic [127:0] r_key;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [31:0]  w_p0;
    logic [31:0]  w_p1;
    logic [31:0]  w_p2;
    logic [31:0]  w_p3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [7:0]   w_next_rcon;

    // Words 1..3 of the previous key fall out of adjacent-word XORs.
    assign w_p3 = r_key[127:96] ^ r_key[95:64];
    assign w_p2 = r_key[95:64]  ^ r_key[63:32];
    assign w_p1 = r_key[63:32]  ^ r_key[31:0];
    assign w_rot = {w_p3[7:0], w_p3[31:8]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[g*8 +: 8]),
                .o_byte (w_sub[g*8 +: 8])
            );
        end
    endgenerate

    assign w_p0        = r_key[31:0] ^ {w_sub[31:8], w_sub[7:0] ^ r_rcon};
    assign w_next_rcon = (r_rcon == 8'h1B) ? 8'h80 : {1'b0, r_rcon[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_rcon  <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key   <= key_last_in;
                        r_rcon  <= rcon_last_in;
                        r_round <= c_last_round;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (key_ready) begin
                        if (r_round == 4'd0) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_key   <= {w_p3, w_p2, w_p1, w_p0};
                            r_rcon  <= w_next_rcon;
                            r_round <= r_round - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign key_out   = r_key;
    assign round_out = r_round;
    assign key_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_scheduling.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_key_scheduling
// Description : Directed/random bench for the inverse key schedule engine,
//               checked against a word-level FIPS-197 key expansion model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_aes_inv_key_scheduling;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_last_in;
    logic [7:0]   rcon_last_in;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_t   [256];
    logic [127:0] m_keys   [11];
    logic [7:0]   m_rc     [11];
    logic [127:0] obs_keys [11];

    aes_inv_key_scheduling #(.NUM_ROUNDS(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_last_in  (key_last_in),
        .rcon_last_in (rcon_last_in),
        .key_out      (key_out),
        .round_out    (round_out),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // FIPS-197 hex string order (first byte leftmost) to the packed layout.
    function automatic logic [127:0] fips(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = x[127-8*k -: 8];
        return r;
    endfunction

    // S-box table from the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] inv_rcon(input logic [7:0] rc);
        return (rc == 8'h1B) ? 8'h80 : rc / 2;
    endfunction

    // Walk the FIPS-197 word recurrence w[i] = w[i-4] ^ temp backwards.
    task automatic compute_model(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [31:0] s;
        m_rc[10] = rc;
        for (int r = 10; r >= 1; r--) m_rc[r-1] = inv_rcon(m_rc[r]);
        for (int i = 0; i < 4; i++) w[40+i] = k[32*i +: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) s[8*j +: 8] = sbox_t[t[8*((j+1)%4) +: 8]];
                t = s ^ {24'h0, m_rc[i/4]};
            end
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_keys[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    // mode 0: ready high; 1: random ready; 2: ready high plus a stray start mid-stream.
    task automatic run_stream(input logic [127:0] k, input logic [7:0] rc, input int mode,
                              input bit skip_start, input bit chain,
                              input logic [127:0] next_k, input logic [7:0] next_rc);
        int           idx;
        int           n;
        bit           prev_stall;
        logic [127:0] prev_key;
        logic [3:0]   prev_round;
        compute_model(k, rc);
        if (!skip_start) begin
            key_last_in  = k;
            rcon_last_in = rc;
            start        = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        idx        = 10;
        n          = 0;
        prev_stall = 1'b0;
        prev_key   = '0;
        prev_round = '0;
        while (idx >= 0 && n < 200) begin
            check("valid", {127'h0, key_valid}, 128'h1);
            check("busy", {127'h0, busy}, 128'h1);
            check("done_low", {127'h0, done}, 128'h0);
            if (prev_stall) begin
                check("stall_key", key_out, prev_key);
                check("stall_round", {124'h0, round_out}, {124'h0, prev_round});
            end
            check("key", key_out, m_keys[idx]);
            check("round", {124'h0, round_out}, 128'(idx));
            check("rcon", {120'h0, dut.r_rcon}, {120'h0, m_rc[idx]});
            obs_keys[idx] = key_out;
            if (mode == 2 && idx == 6) begin
                start        = 1'b1;
                key_last_in  = ~k;
                rcon_last_in = 8'h55;
            end else begin
                start = 1'b0;
            end
            key_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stall = !key_ready;
            prev_key   = key_out;
            prev_round = round_out;
            if (key_ready) idx--;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("timeout", 128'(n < 200), 128'h1);
        check("done_pulse", {127'h0, done}, 128'h1);
        check("valid_end", {127'h0, key_valid}, 128'h0);
        check("busy_end", {127'h0, busy}, 128'h0);
        if (mode != 1) check("done_cycle", 128'(n + 1), 128'd12);
        if (chain) begin
            key_last_in  = next_k;
            rcon_last_in = next_rc;
            start        = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
            check("done_once", {127'h0, done}, 128'h0);
        end
    endtask

    initial begin
        logic [127:0] k1;
        logic [127:0] k2;
        int           n;
        build_sbox();
        rst          = 1'b1;
        start        = 1'b0;
        key_ready    = 1'b0;
        key_last_in  = '0;
        rcon_last_in = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", {127'h0, key_valid}, 128'h0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        check("rst_round", {124'h0, round_out}, 128'h0);
        check("rst_key", key_out, 128'h0);
        check("rst_rcon", {120'h0, dut.r_rcon}, 128'h0);
        rst       = 1'b0;
        key_ready = 1'b1;
        @(negedge clk);
        check("idle_ready_valid", {127'h0, key_valid}, 128'h0);
        check("idle_ready_done", {127'h0, done}, 128'h0);

        // FIPS-197 A.1 round-10 key
        run_stream(fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6), 8'h36, 0, 1'b0, 1'b0, '0, 8'h00);
        check("fips_r10", obs_keys[10], fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        check("fips_r9", obs_keys[9], fips(128'hac7766f319fadc2128d12941575c006e));
        check("fips_r1", obs_keys[1], fips(128'ha0fafe1788542cb123a339392a6c7605));
        check("fips_r0", obs_keys[0], fips(128'h2b7e151628aed2a6abf7158809cf4f3c));

        // Backpressure with random keys
        for (int t = 0; t < 3; t++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            run_stream(k1, (t == 2) ? 8'($urandom) : 8'h36, 1, 1'b0, 1'b0, '0, 8'h00);
        end

        // Stray start mid-stream, then restart in the done cycle
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        run_stream(k1, 8'h36, 2, 1'b0, 1'b1, k2, 8'h36);
        run_stream(k2, 8'h36, 0, 1'b1, 1'b0, '0, 8'h00);

        // Reset at round 5
        k1           = {$urandom, $urandom, $urandom, $urandom};
        key_last_in  = k1;
        rcon_last_in = 8'h36;
        key_ready    = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        while (round_out != 4'd5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_r5", 128'(n < 40), 128'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_valid", {127'h0, key_valid}, 128'h0);
        check("mrst_busy", {127'h0, busy}, 128'h0);
        check("mrst_done", {127'h0, done}, 128'h0);
        repeat (3) begin
            @(negedge clk);
            check("mrst_no_done", {127'h0, done}, 128'h0);
            check("mrst_idle", {127'h0, key_valid}, 128'h0);
        end
        run_stream(k1, 8'h36, 0, 1'b0, 1'b0, '0, 8'h00);

        // All-zero key with rcon 0x01
        run_stream(128'h0, 8'h01, 0, 1'b0, 1'b0, '0, 8'h00);
        check("zero_r10", obs_keys[10], 128'h0);
        check("zero_r0_round", {124'h0, round_out}, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_inv_key_scheduling.md
# aes_inv_key_scheduling

Sequential AES-128 inverse key-schedule engine for the decryption datapath. It is loaded once with the final (round-10) round key and its round constant. It then walks the key expansion backwards, one round per cycle, emitting round keys 10, 9, …, 0 on a valid/ready stream. The decryption round pipeline consumes these keys in exactly the order needed for InvCipher, so no 11-entry key table is stored.

## Interface
- `NUM_ROUNDS`, default 10: number of backward steps; round keys emitted = NUM_ROUNDS+1. Only 10 (AES-128) is supported.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  load request; sampled only in IDLE.
- `key_last_in`  in  128  round-10 key.
  - Word i at `[i*32 +: 32]`.
  - Byte j of a word at `[j*8 +: 8]`.
  - FIPS-197 key byte k maps to bits `[8k+7:8k]`.
- `rcon_last_in`  in  8  Rcon that produced `key_last_in` (0x36 for AES-128).
- `key_out`  out  128  current round key, same packing as `key_last_in`.
- `round_out`  out  4  round index of `key_out` (10 down to 0).
- `key_valid`  out  1  `key_out`/`round_out` valid.
- `key_ready`  in  1  consumer accepts; transfer when `key_valid && key_ready`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after round-0 key is accepted.

## Operation
- States:
  - IDLE: `key_valid`=0, `busy`=0.
  - EMIT: `key_valid`=1, `busy`=1.
- Registers: `key_r` (128), `rcon_r` (8), `round_r` (4).
  - `rcon_r` always holds the Rcon that was used to derive `key_r` from the previous round key.
- IDLE with `start`=1 → EMIT:
  - `key_r`←`key_last_in`
  - `rcon_r`←`rcon_last_in`
  - `round_r`←NUM_ROUNDS
- EMIT without a transfer: all registers hold; `key_out`/`round_out` must stay stable while `key_valid && !key_ready`.
- EMIT with a transfer and `round_r`≠0: apply the backward step.
  - `key_r`←prev(`key_r`, `rcon_r`)
  - `rcon_r`←inv_rcon(`rcon_r`)
  - `round_r`←`round_r`−1
  - Stay in EMIT.
- EMIT with a transfer and `round_r`=0: go to IDLE; assert `done` for exactly that next cycle.
- prev(n, rc), with n0..n3 the words of n:
  - w3=n3^n2, w2=n2^n1, w1=n1^n0
  - Rotate w3 one byte toward lower significance, top byte filled from byte 0: r = {w3[7:0], w3[31:8]}.
  - S = S-box applied to each byte of r, using four `aes_sbox` instances.
  - w0 = n0 ^ {S[31:8], S[7:0]^rc}.
- inv_rcon(rc):
  - rc==0x1B → 0x80.
  - Otherwise → rc>>1 (zero-fill).
  - Result for rc=0x01 is 0x00 and is never used.
- `start` while `busy`=1 is ignored. `start` in the same cycle `done` is asserted is accepted, since the state is already IDLE.
- `key_ready` while `key_valid`=0 has no effect.
- Input values other than the round-10 key / 0x36 pair are legal: the block steps blindly and performs no checking.

## Timing
- Reset values:
  - `key_valid`=0, `busy`=0, `done`=0, `round_out`=0, `key_out`=0.
  - Internal: `rcon_r`=0, state IDLE.
- Reset asserted mid-sequence: the next edge forces IDLE. The partial stream is abandoned with no `done`.
- `start` sampled high at edge T gives `key_valid`=1 and `round_out`=10 after T.
- A transfer at edge t presents the next round key after t: one cycle per key, with no bubbles.
- With `key_ready` held high, the 11 keys take 11 consecutive cycles; `done` is high in the 12th cycle after start.
- The backward step is purely combinational from `key_r` to the `key_r` D-input: one round of XOR plus S-box per cycle.
- `key_out`=`key_r`, `round_out`=`round_r`: both are registered outputs.

## Test plan
- FIPS-197 A.1 key, `ready` high.
  - Stimulus: load d014f9a8c9ee2589e13f0cc8b6630ca6 (byte order as packed) with rcon 0x36.
  - Required: round 10 = d014f9a8…, round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `done` in cycle 12.
- Backpressure:
  - Stimulus: toggle `key_ready` pseudo-randomly.
  - Required: same 11 keys in order; `key_out`/`round_out` stable during every stall; `done` once.
- Rcon wrap:
  - Check internal `rcon_r` sequence 36,1B,80,40,20,10,08,04,02,01.
  - Check the round-2 key from round-3 uses 0x04.
- Ignored start:
  - Stimulus: pulse `start` with a different key mid-stream.
  - Required: stream unaffected; a new `start` in the `done` cycle starts a fresh sequence the next cycle.
- Mid-stream reset:
  - Stimulus: assert `rst` at round 5.
  - Required: `key_valid`=0 and `busy`=0 the next cycle; no `done` pulse.
  - Required: a subsequent start produces the full correct sequence.
- All-zero load with rcon 0x01, `ready` high.
  - Required: round 10 = 0, round 9 = prev(0, 0x01).
  - Required: `round_out` reaches 0 without underflow; state returns to IDLE.
